// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared op/state encodings and iteration-counter sizing for mult_div_unit
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// rtl/mult_div_sign_fix.sv - conditional two's-complement negation
// Used both to take operand magnitudes and to restore result signs.
module mult_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write path
// Optional macro MULT_DIV_UNSIGNED_EN enables the unsigned ops; without it op[0] is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mult_div_pkg::*;

  localparam int               CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   mcand;
  logic               div_q;
  logic               neg_res;
  logic               neg_rem;

  logic               op_div;
  logic               op_signed;
  logic               sign_a;
  logic               sign_b;
  logic               div_by_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign op_div = (op_e'(op) == OP_DIV) || (op_e'(op) == OP_DIVU);
`ifdef MULT_DIV_UNSIGNED_EN
  assign op_signed = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
`else
  assign op_signed = 1'b1;
`endif
  assign sign_a      = op_signed & a[WIDTH-1];
  assign sign_b      = op_signed & b[WIDTH-1];
  assign div_by_zero = op_div && (b == '0);

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .result(a_mag));
  mult_div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .result(b_mag));

  // p holds {partial product, multiplier} or {remainder, quotient/dividend}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{p[0]}}};
  assign mul_next  = {mul_sum, p[WIDTH-1:1]};
  assign div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand};
  assign div_rem   = div_shift[WIDTH-1:0] - mcand;
  assign div_next  = div_ge ? {div_rem, p[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mult_div_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.value(p), .negate(neg_res), .result(prod_fix));
  mult_div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value(p[WIDTH-1:0]), .negate(neg_res), .result(quo_fix));
  mult_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value(p[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      p       <= '0;
      mcand   <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done  <= 1'b0;
          div0  <= 1'b0;
          state <= ST_IDLE;
          if (start) begin
            cnt     <= '0;
            div_q   <= op_div;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            if (div_by_zero) begin
              // hi/lo are deliberately left untouched on divide-by-zero.
              state <= ST_DONE;
              done  <= 1'b1;
              div0  <= 1'b1;
            end else begin
              state <= ST_CALC;
              busy  <= 1'b1;
              mcand <= op_div ? b_mag : a_mag;
              p     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            end
          end
        end
        ST_CALC: begin
          p   <= div_q ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (div_q) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO.
REQ-002 SHALL have port clk  in  1  as the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  in  1  as the reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  to request an operation.
REQ-005 SHALL have port op  in  2  to select the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  in  WIDTH  as the multiplicand or dividend (A register value).
REQ-007 SHALL have port b  in  WIDTH  as the multiplier or divisor (B register value).
REQ-008 SHALL have port busy  out  1  to indicate an operation in progress.
REQ-009 SHALL have port done  out  1  as a one-cycle completion pulse.
REQ-010 SHALL have port div0  out  1  to flag divide-by-zero; valid only while done=1.
REQ-011 SHALL have ports hi  out  WIDTH  and  lo  out  WIDTH  as result registers, feeding the CPU HI/LO write path.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC/FIX SHALL be ignored and SHALL NOT disturb the running operation.
REQ-014 SHALL capture a, b and op on the accepting edge (edge 0), with later input changes having no effect on the result.
REQ-015 SHALL run CALC for exactly WIDTH edges, one shift-add (multiply) or restoring-subtract (divide) iteration per edge, then FIX for one edge for sign correction, then DONE for one cycle.
REQ-016 SHALL load hi/lo and enter DONE on edge WIDTH+1 after acceptance; done=1 only in DONE; busy=1 only in CALC and FIX.
REQ-017 SHALL compute multiply as the full 2*WIDTH-bit product {hi,lo}, signed for MULT and unsigned for MULTU.
REQ-018 SHALL produce lo=quotient and hi=remainder for divide, with signed DIV quotient truncating toward zero and remainder taking the dividend's sign.
REQ-019 SHALL make DIV of MIN by -1 yield lo=MIN, hi=0, with no flag.
REQ-020 SHALL skip CALC/FIX for DIV/DIVU with b=0 at acceptance and enter DONE on edge 0, with done=1, div0=1, hi/lo unchanged.
REQ-021 SHALL hold hi/lo between completions; div0=0 whenever done=0.
REQ-022 SHALL, when start is asserted in DONE, accept the new operation on that edge (back-to-back), with done falling.

Reset
REQ-023 SHALL, on reset low at any time including mid-operation, immediately force IDLE, busy=0, done=0, div0=0, hi=0, lo=0, and clear internal counters and operand registers.
REQ-024 SHALL keep start ignored while reset is low; the first acceptance is possible on the first rising edge with reset high.

Configuration
REQ-025 SHALL, with macro MULT_DIV_UNSIGNED_EN defined, support all four ops as specified.
REQ-026 SHALL, with MULT_DIV_UNSIGNED_EN undefined, ignore op[0] and treat MULTU as MULT and DIVU as DIV, removing the unsigned datapath; timing is otherwise unchanged.

Structure
REQ-027 SHALL take the op encoding enum, FSM state enum and iteration-counter width (clog2(WIDTH+1)) from shared package mult_div_pkg.
REQ-028 SHALL place operand absolute value and result negation in one natural sub-module, mult_div_sign_fix, instantiated for operand conditioning and for the FIX step; everything else stays in mult_div_unit.

Verification (WIDTH=32)
REQ-029 SHALL verify that MULT a=FFFFFFFD b=00000007 gives, 33 edges after acceptance, done=1, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-030 SHALL verify that MULTU a=FFFFFFFF b=00000002 gives hi=00000001, lo=FFFFFFFE, and with the macro undefined gives hi=FFFFFFFF, lo=FFFFFFFE.
REQ-031 SHALL verify that DIV a=FFFFFFF9 b=00000002 gives lo=FFFFFFFD, hi=FFFFFFFF, and that DIV a=80000000 b=FFFFFFFF gives lo=80000000, hi=00000000.
REQ-032 SHALL verify that DIVU with b=0 and prior hi/lo=1234/5678 gives done=1 and div0=1 on the edge after acceptance, hi/lo unchanged and busy never high.
REQ-033 SHALL verify that start pulsed at CALC edge 10 with different operands leaves the first result intact, and that done is followed immediately by a back-to-back start completing 33 edges later.
REQ-034 SHALL verify that reset low at CALC edge 15 forces busy=0 and hi=lo=0 asynchronously, and that no done appears afterward without a new start.
